// File: rtl/inst_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Optional feature macro (used by the top): PREFETCH_PERF_EN.
package inst_prefetch_queue_pkg;

    // Fetch controller states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT      = 2'd1,
        WAIT_DROP = 2'd2
    } pq_state_t;

    localparam logic [31:0] INST_BYTES  = 32'd4;
    localparam logic [31:0] PQ_RESET_PC = 32'h0000_0000;

    // One queued fetch: the instruction word and the address it came from
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } pq_entry_t;

    // Sequential successor of a fetch address, wrapping modulo 2^32
    function automatic logic [31:0] pq_next_pc(input logic [31:0] pc);
        return pc + INST_BYTES;
    endfunction

endpackage

// File: rtl/inst_prefetch_queue_fifo.sv
// pq_fifo: circular buffer of {inst, pc} entries for the prefetch queue.
// Pushes into a full buffer and pops from an empty one are ignored; a flush
// discards everything and wins over a simultaneous push or pop.
module pq_fifo
    import inst_prefetch_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  pq_entry_t     i_pushEntry,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic [AW:0]   o_count,
    output logic          o_empty,
    output pq_entry_t     o_head
);

    logic [AW-1:0] r_rdPtr;
    logic [AW-1:0] r_wrPtr;
    logic [AW:0]   r_count;
    pq_entry_t     r_mem [DEPTH];

    logic w_full;
    logic w_doPush;
    logic w_doPop;

    assign o_empty  = (r_count == '0);
    assign w_full   = (r_count == (AW + 1)'(DEPTH));
    assign w_doPush = i_push && !w_full && !i_flush;
    assign w_doPop  = i_pop && !o_empty && !i_flush;
    assign o_count  = r_count;
    assign o_head   = r_mem[r_rdPtr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            if (w_doPush && !w_doPop) begin
                r_count <= r_count + (AW + 1)'(1);
            end else if (!w_doPush && w_doPop) begin
                r_count <= r_count - (AW + 1)'(1);
            end
        end
    end

    // Entry storage, written only when a push is accepted
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushEntry;
        end
    end

endmodule

// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: fetches sequential instruction words from a multi-cycle
// memory (one request outstanding at a time) and buffers them ahead of IF.
// A redirect from IF flushes queued words and drops any in-flight response.
// Optional macro PREFETCH_PERF_EN adds perf_drop_cnt / perf_empty_cnt outputs.
module inst_prefetch_queue
    import inst_prefetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = PQ_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_adr,
    input  logic        deq,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [31:0] out_next_adr,
    output logic        mem_req,
    output logic [31:0] mem_adr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
`ifdef PREFETCH_PERF_EN
    ,
    output logic [15:0] perf_drop_cnt,
    output logic [15:0] perf_empty_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    pq_state_t   r_state;
    logic [31:0] r_fetchPc;
    logic        r_memReq;
    logic [31:0] r_memAdr;

    logic [CW-1:0] w_count;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    pq_entry_t     w_head;
    pq_entry_t     w_pushEntry;

    // Only a response to a kept request is queued, and never in a redirect cycle
    assign w_push      = (r_state == WAIT) && mem_ack && !redirect;
    assign w_pop       = deq && !w_empty && !redirect;
    assign w_pushEntry = '{inst: mem_rdata, pc: r_fetchPc};
    // The outstanding request is already covered: issue only happens from IDLE
    assign w_full      = (w_count == CW'(DEPTH));

    pq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_pushEntry (w_pushEntry),
        .i_pop       (w_pop),
        .i_flush     (redirect),
        .o_count     (w_count),
        .o_empty     (w_empty),
        .o_head      (w_head)
    );

    // Head is forced to zero while empty so reset shows out_pc=0, out_next_adr=4
    assign out_valid    = !w_empty;
    assign out_inst     = out_valid ? w_head.inst : 32'd0;
    assign out_pc       = out_valid ? w_head.pc : 32'd0;
    assign out_next_adr = pq_next_pc(out_pc);
    assign mem_req      = r_memReq;
    assign mem_adr      = r_memAdr;

    // Fetch control: one request at a time, redirect first, fetch_pc tracks the next word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_fetchPc <= RESET_PC;
            r_memReq  <= 1'b0;
            r_memAdr  <= 32'd0;
        end else begin
            r_memReq <= 1'b0;
            if (redirect) begin
                r_fetchPc <= redirect_adr;
                if ((r_state != IDLE) && !mem_ack) begin
                    r_state <= WAIT_DROP;
                end else begin
                    r_state <= IDLE;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        if (!w_full) begin
                            r_memReq <= 1'b1;
                            r_memAdr <= r_fetchPc;
                            r_state  <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (mem_ack) begin
                            r_fetchPc <= pq_next_pc(r_fetchPc);
                            r_state   <= IDLE;
                        end
                    end
                    WAIT_DROP: begin
                        if (mem_ack) begin
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

`ifdef PREFETCH_PERF_EN
    logic        w_dropAck;
    logic        r_seenEnq;
    logic [15:0] r_dropCnt;
    logic [15:0] r_emptyCnt;

    assign w_dropAck      = mem_ack && (((r_state == WAIT) && redirect) || (r_state == WAIT_DROP));
    assign perf_drop_cnt  = r_dropCnt;
    assign perf_empty_cnt = r_emptyCnt;

    // Saturating counters for discarded responses and starved cycles after the first word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_seenEnq  <= 1'b0;
            r_dropCnt  <= 16'd0;
            r_emptyCnt <= 16'd0;
        end else begin
            if (w_push) begin
                r_seenEnq <= 1'b1;
            end
            if (w_dropAck && (r_dropCnt != 16'hFFFF)) begin
                r_dropCnt <= r_dropCnt + 16'd1;
            end
            if (r_seenEnq && w_empty && (r_emptyCnt != 16'hFFFF)) begin
                r_emptyCnt <= r_emptyCnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Testbench for inst_prefetch_queue. The expected instruction stream is the
// sequential run of addresses starting at the last reset/redirect target; the
// stimulus keeps a queue of upcoming expected PCs and a monitor pops and
// compares it whenever IF consumes a valid head.
module tb_inst_prefetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DATA_KEY = 32'hA5A5_0000;
    localparam logic [31:0] JUNK     = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_adr;
    logic        deq;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_next_adr;
    logic        mem_req;
    logic [31:0] mem_adr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef PREFETCH_PERF_EN
    logic [15:0] perf_drop_cnt;
    logic [15:0] perf_empty_cnt;
`endif

    int          errors    = 0;
    int          checks    = 0;
    int          memLat    = 2;
    bit          doubleAck = 1'b0;
    int          popCount  = 0;
    logic [31:0] modelPc;
    logic [31:0] monPc;
    logic [31:0] expQ[$];
    logic [31:0] reqLog[$];

    inst_prefetch_queue #(
        .DEPTH    (4),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .redirect     (redirect),
        .redirect_adr (redirect_adr),
        .deq          (deq),
        .out_valid    (out_valid),
        .out_inst     (out_inst),
        .out_pc       (out_pc),
        .out_next_adr (out_next_adr),
        .mem_req      (mem_req),
        .mem_adr      (mem_adr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
`ifdef PREFETCH_PERF_EN
        ,
        .perf_drop_cnt  (perf_drop_cnt),
        .perf_empty_cnt (perf_empty_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no completion, required finish within 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic topUp();
        while (expQ.size() < 16) begin
            expQ.push_back(modelPc);
            modelPc = modelPc + 32'd4;
        end
    endtask

    task automatic resetStream(input logic [31:0] adr);
        expQ.delete();
        modelPc = adr;
        topUp();
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
        topUp();
    endtask

    task automatic waitNewReq(output logic [31:0] adr, output bit ok);
        ok  = 1'b0;
        adr = 32'd0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            topUp();
            if (mem_req) begin
                ok  = 1'b1;
                adr = mem_adr;
            end
        end
    endtask

    task automatic waitValid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            topUp();
            if (out_valid) ok = 1'b1;
        end
    endtask

    // Memory model: answers each request after memLat cycles with pc ^ DATA_KEY;
    // with doubleAck it holds ack one extra cycle carrying junk
    initial begin
        logic [31:0] adr;
        int          lat;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (rst && mem_req) begin
                adr = mem_adr;
                lat = memLat;
                repeat (lat) @(posedge clk);
                #1;
                mem_ack   = 1'b1;
                mem_rdata = adr ^ DATA_KEY;
                if (doubleAck) begin
                    @(posedge clk);
                    #1;
                    mem_rdata = JUNK;
                end
                @(posedge clk);
                #1;
                mem_ack   = 1'b0;
                mem_rdata = 32'd0;
            end
        end
    end

    // Record every issued request address
    always @(negedge clk) begin
        if (rst && mem_req) reqLog.push_back(mem_adr);
    end

    // Scoreboard monitor: each consumed head must be the next word of the expected stream
    always @(negedge clk) begin
        if (rst && !redirect && deq && out_valid) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard: got head pc %h, required an expected entry (queue empty)", out_pc);
            end else begin
                monPc = expQ.pop_front();
                checkOutput("headPc", out_pc, monPc);
                checkOutput("headInst", out_inst, monPc ^ DATA_KEY);
                checkOutput("headNextAdr", out_next_adr, monPc + 32'd4);
                popCount++;
            end
        end
    end

    initial begin
        logic [31:0] adr;
        bit          ok;
        bit          found;
        int          n0;
        int          popsBefore;
`ifdef PREFETCH_PERF_EN
        logic [15:0] dropBefore;
`endif
        rst          = 1'b0;
        redirect     = 1'b0;
        redirect_adr = 32'd0;
        deq          = 1'b0;
        resetStream(RESET_PC);

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstOutValid", 32'(out_valid), 32'd0);
        checkOutput("rstMemReq", 32'(mem_req), 32'd0);
        checkOutput("rstOutInst", out_inst, 32'd0);
        checkOutput("rstOutPc", out_pc, 32'd0);
        checkOutput("rstNextAdr", out_next_adr, 32'd4);
        checkOutput("rstMemAdr", mem_adr, 32'd0);

        // First request in the first clock after release
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("firstReq", 32'(mem_req), 32'd1);
        checkOutput("firstAdr", mem_adr, RESET_PC);

        // Fill with no consumer: exactly 0,4,8,12 requested
        repeat (40) applyStimulus();
        checkOutput("fillReqCount", 32'(reqLog.size()), 32'd4);
        for (int i = 0; i < 4 && i < reqLog.size(); i++) begin
            checkOutput("fillReqAdr", reqLog[i], 32'(i * 4));
        end
        checkOutput("fillValid", 32'(out_valid), 32'd1);
        checkOutput("fillPc", out_pc, 32'd0);
        checkOutput("fillInst", out_inst, 32'hA5A5_0000);
        checkOutput("fillNextAdr", out_next_adr, 32'd4);

        // One deq frees one slot: exactly one request to 16
        deq = 1'b1;
        applyStimulus();
        deq = 1'b0;
        repeat (20) applyStimulus();
        checkOutput("refillReqCount", 32'(reqLog.size()), 32'd5);
        if (reqLog.size() > 4) checkOutput("refillAdr", reqLog[4], 32'd16);
        checkOutput("refillHeadPc", out_pc, 32'd4);

        // Redirect while a request is outstanding; its ack arrives a cycle later
        deq = 1'b1;
        applyStimulus();
        deq = 1'b0;
        waitNewReq(adr, ok);
        checkOutput("redirReqSeen", 32'(ok), 32'd1);
`ifdef PREFETCH_PERF_EN
        dropBefore = perf_drop_cnt;
`endif
        applyStimulus();
        redirect     = 1'b1;
        redirect_adr = 32'h40;
        resetStream(32'h40);
        applyStimulus();
        redirect = 1'b0;
        @(negedge clk);
        checkOutput("redirFlushValid", 32'(out_valid), 32'd0);
        applyStimulus();
        @(negedge clk);
        checkOutput("redirDropValid", 32'(out_valid), 32'd0);
`ifdef PREFETCH_PERF_EN
        checkOutput("perfDrop1", 32'(perf_drop_cnt), 32'(dropBefore) + 32'd1);
`endif
        waitNewReq(adr, ok);
        checkOutput("redirNextAdr", adr, 32'h40);
        memLat = 1;
        waitValid(ok);
        checkOutput("redirValidSeen", 32'(ok), 32'd1);
        checkOutput("redirHeadPc", out_pc, 32'h40);

        // Redirect in the same cycle as the ack
        waitNewReq(adr, ok);
        checkOutput("sameCycReqSeen", 32'(ok), 32'd1);
`ifdef PREFETCH_PERF_EN
        dropBefore = perf_drop_cnt;
`endif
        applyStimulus();
        redirect     = 1'b1;
        redirect_adr = 32'h100;
        resetStream(32'h100);
        applyStimulus();
        redirect = 1'b0;
        @(negedge clk);
`ifdef PREFETCH_PERF_EN
        checkOutput("perfDrop2", 32'(perf_drop_cnt), 32'(dropBefore) + 32'd1);
`endif
        waitNewReq(adr, ok);
        checkOutput("sameCycNextAdr", adr, 32'h100);
        waitValid(ok);
        checkOutput("sameCycHeadPc", out_pc, 32'h100);
        checkOutput("sameCycHeadInst", out_inst, 32'h100 ^ DATA_KEY);

        // Address wrap at the top of the 32-bit space
        applyStimulus();
        n0           = reqLog.size();
        redirect     = 1'b1;
        redirect_adr = 32'hFFFF_FFF0;
        resetStream(32'hFFFF_FFF0);
        applyStimulus();
        redirect = 1'b0;
        deq      = 1'b1;
        repeat (60) applyStimulus();
        deq   = 1'b0;
        found = 1'b0;
        for (int i = n0; i + 1 < reqLog.size(); i++) begin
            if (reqLog[i] == 32'hFFFF_FFFC && reqLog[i + 1] == 32'd0) found = 1'b1;
        end
        checkOutput("wrapReqToZero", 32'(found), 32'd1);

        // Asynchronous reset in the middle of a request
        deq = 1'b1;
        waitNewReq(adr, ok);
        checkOutput("midRstReqSeen", 32'(ok), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("asyncRstMemReq", 32'(mem_req), 32'd0);
        checkOutput("asyncRstValid", 32'(out_valid), 32'd0);
        checkOutput("asyncRstPc", out_pc, 32'd0);
        checkOutput("asyncRstInst", out_inst, 32'd0);
        checkOutput("asyncRstNext", out_next_adr, 32'd4);
        checkOutput("asyncRstMemAdr", mem_adr, 32'd0);
`ifdef PREFETCH_PERF_EN
        checkOutput("asyncRstPerfDrop", 32'(perf_drop_cnt), 32'd0);
`endif
        deq = 1'b0;
        resetStream(RESET_PC);
        repeat (6) applyStimulus();
        rst = 1'b1;
        waitNewReq(adr, ok);
        checkOutput("postRstAdr", adr, RESET_PC);
        waitValid(ok);
        checkOutput("postRstHeadPc", out_pc, RESET_PC);
        checkOutput("postRstHeadInst", out_inst, RESET_PC ^ DATA_KEY);

        // Randomized traffic: consumer, latency, redirects and extra protocol-error acks
        popsBefore = popCount;
        repeat (1500) begin
            applyStimulus();
            deq       = 1'($urandom_range(0, 1));
            memLat    = int'($urandom_range(1, 3));
            doubleAck = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 39) == 0) begin
                redirect     = 1'b1;
                redirect_adr = $urandom() & 32'hFFFF_FFFC;
                resetStream(redirect_adr);
            end else begin
                redirect = 1'b0;
            end
        end
        deq       = 1'b0;
        redirect  = 1'b0;
        doubleAck = 1'b0;
        repeat (10) applyStimulus();
        checkOutput("randomProgress", 32'(popCount - popsBefore >= 50), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
